// File: rtl/mips32_mem_dump_if.sv
// Bundles the memory read port and the dump stream of the pipe_MIPS32 debug dumper.
// master = the dumper, slave = memory plus dump consumer.
interface mips32_mem_dump_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic              dump_valid;
  logic              dump_ready;
  logic [ADDR_W-1:0] dump_addr;
  logic [DATA_W-1:0] dump_data;
  logic              dump_last;

  modport master (
    output mem_rd_en, mem_rd_addr,
    input  mem_rd_data,
    output dump_valid, dump_addr, dump_data, dump_last,
    input  dump_ready
  );

  modport slave (
    input  mem_rd_en, mem_rd_addr,
    output mem_rd_data,
    input  dump_valid, dump_addr, dump_data, dump_last,
    output dump_ready
  );
endinterface

// File: rtl/mips32_mem_dump.sv
// Debug read port: after start and CPU halt, streams a word range of the unified memory
// out as {addr, data} beats over valid/ready, one word every three cycles at best.
module mips32_mem_dump #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 11
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic              halted_in,
  output logic              busy,
  output logic              done,
  output logic              err,
  mips32_mem_dump_if.master bus
);

  localparam logic [CNT_W-1:0] MaxCount = CNT_W'(2 ** ADDR_W);

  typedef enum logic [2:0] {
    StIdle,
    StWaitHalt,
    StRd,
    StCap,
    StSend,
    StFin
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] cur_addr_q;
  logic [CNT_W-1:0]  remaining_q;
  logic              rd_en_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              valid_q;
  logic [ADDR_W-1:0] dump_addr_q;
  logic [DATA_W-1:0] dump_data_q;
  logic              last_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      valid_q     <= 1'b0;
      dump_addr_q <= '0;
      dump_data_q <= '0;
      last_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (word_count == '0) begin
              err_q <= 1'b1;
            end else begin
              cur_addr_q  <= start_addr;
              remaining_q <= (word_count > MaxCount) ? MaxCount : word_count;
              busy_q      <= 1'b1;
              state_q     <= StWaitHalt;
            end
          end
        end
        StWaitHalt: begin
          if (halted_in) begin
            rd_en_q   <= 1'b1;
            rd_addr_q <= cur_addr_q;
            state_q   <= StRd;
          end
        end
        StRd: begin
          rd_en_q <= 1'b0;
          state_q <= StCap;
        end
        StCap: begin
          // Read data is valid in this cycle, one cycle after the strobe.
          valid_q     <= 1'b1;
          dump_data_q <= bus.mem_rd_data;
          dump_addr_q <= cur_addr_q;
          last_q      <= (remaining_q == CNT_W'(1));
          state_q     <= StSend;
        end
        StSend: begin
          if (bus.dump_ready) begin
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            remaining_q <= remaining_q - CNT_W'(1);
            cur_addr_q  <= cur_addr_q + ADDR_W'(1);
            if (remaining_q != CNT_W'(1)) begin
              rd_en_q   <= 1'b1;
              rd_addr_q <= cur_addr_q + ADDR_W'(1);
              state_q   <= StRd;
            end else begin
              done_q  <= 1'b1;
              state_q <= StFin;
            end
          end
        end
        StFin: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.mem_rd_en   = rd_en_q;
  assign bus.mem_rd_addr = rd_addr_q;
  assign bus.dump_valid  = valid_q;
  assign bus.dump_addr   = dump_addr_q;
  assign bus.dump_data   = dump_data_q;
  assign bus.dump_last   = last_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign err             = err_q;

endmodule

// File: tb/tb_mips32_mem_dump.sv
// Scoreboard bench for mips32_mem_dump: a synchronous memory model feeds the read port and
// expected {addr, data, last} beats are queued at start and popped on each handshake.
module tb_mips32_mem_dump;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 11;
  localparam int          NWORDS = 1 << ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic              l;
  } exp_t;

  logic              clk1 = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] start_addr = '0;
  logic [CNT_W-1:0]  word_count = '0;
  logic              halted_in = 1'b0;
  logic              busy;
  logic              done;
  logic              err;

  mips32_mem_dump_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mips32_mem_dump #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk1       (clk1),
    .rst_n      (rst_n),
    .start      (start),
    .start_addr (start_addr),
    .word_count (word_count),
    .halted_in  (halted_in),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .bus        (bus.master)
  );

  always #5 clk1 = ~clk1;

  logic [DATA_W-1:0] mem [NWORDS];
  always @(posedge clk1) if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_rd_addr];

  int rd_cnt = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  always @(negedge clk1) begin
    if (bus.mem_rd_en) rd_cnt <= rd_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (err) err_cnt <= err_cnt + 1;
  end

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  task automatic push_range(input int base, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.a = ADDR_W'((base + i) % NWORDS);
      e.d = mem[e.a];
      e.l = (i == n - 1);
      sb.push_back(e);
    end
  endtask

  task automatic do_start(input int a, input int c);
    @(negedge clk1);
    start = 1'b1;
    start_addr = ADDR_W'(a);
    word_count = CNT_W'(c);
    @(negedge clk1);
    start = 1'b0;
    #1;
  endtask

  // Accepts n beats; while beat stall_idx is presented, holds ready low for stall_len cycles.
  task automatic collect(input int n, input int stall_idx, input int stall_len, input int budget);
    int   got = 0;
    int   left = stall_len;
    int   cyc = 0;
    exp_t e;
    exp_t obs;
    exp_t held = '0;
    while (got < n && cyc < budget) begin
      @(negedge clk1);
      cyc++;
      obs = {bus.dump_addr, bus.dump_data, bus.dump_last};
      if (bus.dump_valid && got == stall_idx && left > 0) begin
        if (left == stall_len) held = obs;
        else begin
          checks++;
          if (obs !== held) begin
            failures++;
            $display("FAIL stall_stable: got %h required %h", obs, held);
          end
        end
        bus.dump_ready = 1'b0;
        left--;
      end else begin
        if (got == stall_idx && left > 0 && left < stall_len) begin
          checks++;
          failures++;
          $display("FAIL stall_valid_drop: dump_valid=0 required 1");
        end
        bus.dump_ready = 1'b1;
        if (bus.dump_valid) begin
          checks++;
          if (sb.size() == 0) begin
            failures++;
            $display("FAIL beat_unexpected: got %h required none", obs);
          end else begin
            e = sb.pop_front();
            if (obs !== e) begin
              failures++;
              $display("FAIL beat_%0d: got a=%0d d=%h l=%b required a=%0d d=%h l=%b",
                       got, obs.a, obs.d, obs.l, e.a, e.d, e.l);
            end
          end
          got++;
        end
      end
    end
    if (got < n) begin
      checks++;
      failures++;
      $display("FAIL collect_timeout: got %0d beats required %0d", got, n);
    end
    @(negedge clk1);
    bus.dump_ready = 1'b0;
    checks++;
    if (bus.dump_valid !== 1'b0) begin
      failures++;
      $display("FAIL valid_after_accept: got %b required 0", bus.dump_valid);
    end
  endtask

  task automatic wait_idle(input int budget, input int done0, input int rd0, input int nrd);
    int cyc = 0;
    while (busy && cyc < budget) begin
      @(negedge clk1);
      cyc++;
    end
    #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_timeout: busy=%b required 0", busy);
    end
    checks++;
    if (done_cnt - done0 != 1) begin
      failures++;
      $display("FAIL done_pulses: got %0d required 1", done_cnt - done0);
    end
    checks++;
    if (rd_cnt - rd0 != nrd) begin
      failures++;
      $display("FAIL rd_strobes: got %0d required %0d", rd_cnt - rd0, nrd);
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover: got %0d required 0", sb.size());
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk1);
    #1;
    checks++;
    if (bus.mem_rd_en !== 1'b0) begin failures++; $display("FAIL rst_rd_en: got %b required 0", bus.mem_rd_en); end
    checks++;
    if (bus.mem_rd_addr !== '0) begin failures++; $display("FAIL rst_rd_addr: got %h required 0", bus.mem_rd_addr); end
    checks++;
    if (bus.dump_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b required 0", bus.dump_valid); end
    checks++;
    if ({bus.dump_addr, bus.dump_data, bus.dump_last} !== '0) begin
      failures++;
      $display("FAIL rst_dump_bus: got %h required 0", {bus.dump_addr, bus.dump_data, bus.dump_last});
    end
    checks++;
    if ({busy, done, err} !== 3'b000) begin failures++; $display("FAIL rst_status: got %b required 000", {busy, done, err}); end
    @(negedge clk1);
    rst_n = 1'b1;
  endtask

  // Words 120/121 as left by the ADDI/LW/ADDI/SW/HLT program (85 loaded, 85+45 stored).
  task automatic test_program();
    int d0 = done_cnt;
    int r0 = rd_cnt;
    mem[120] = 32'd85;
    mem[121] = 32'd130;
    halted_in = 1'b1;
    push_range(120, 2);
    do_start(120, 2);
    collect(2, -1, 0, 40);
    wait_idle(10, d0, r0, 2);
  endtask

  task automatic test_wait_halt();
    int d0 = done_cnt;
    int r0 = rd_cnt;
    halted_in = 1'b0;
    bus.dump_ready = 1'b0;
    do_start(5, 4);
    repeat (20) @(negedge clk1);
    #1;
    checks++;
    if (rd_cnt != r0 || busy !== 1'b1 || bus.dump_valid !== 1'b0) begin
      failures++;
      $display("FAIL wait_halt: rd=%0d busy=%b valid=%b required 0 1 0", rd_cnt - r0, busy, bus.dump_valid);
    end
    push_range(5, 4);
    halted_in = 1'b1;
    @(negedge clk1);
    checks++;
    if (bus.mem_rd_en !== 1'b1 || bus.mem_rd_addr !== ADDR_W'(5) || bus.dump_valid !== 1'b0) begin
      failures++;
      $display("FAIL lat_rd: en=%b addr=%0d valid=%b required 1 5 0", bus.mem_rd_en, bus.mem_rd_addr, bus.dump_valid);
    end
    @(negedge clk1);
    checks++;
    if (bus.dump_valid !== 1'b0 || bus.mem_rd_en !== 1'b0) begin
      failures++;
      $display("FAIL lat_cap: valid=%b en=%b required 0 0", bus.dump_valid, bus.mem_rd_en);
    end
    @(negedge clk1);
    checks++;
    if (bus.dump_valid !== 1'b1) begin
      failures++;
      $display("FAIL lat_send: valid=%b required 1", bus.dump_valid);
    end
    collect(4, -1, 0, 60);
    wait_idle(10, d0, r0, 4);
  endtask

  task automatic test_backpressure();
    int d0 = done_cnt;
    int r0 = rd_cnt;
    halted_in = 1'b1;
    push_range(200, 3);
    do_start(200, 3);
    collect(3, 1, 7, 60);
    wait_idle(10, d0, r0, 3);
  endtask

  task automatic test_wrap_clip();
    int d0 = done_cnt;
    int r0 = rd_cnt;
    push_range(1022, 4);
    do_start(1022, 4);
    collect(4, -1, 0, 60);
    wait_idle(10, d0, r0, 4);
    d0 = done_cnt;
    r0 = rd_cnt;
    push_range(0, NWORDS);
    do_start(0, 1500);
    collect(NWORDS, -1, 0, 3 * NWORDS + 20);
    wait_idle(10, d0, r0, NWORDS);
  endtask

  task automatic test_err_busy();
    int d0;
    int r0;
    int e0 = err_cnt;
    do_start(300, 0);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL err_pulse: err=%b busy=%b required 1 0", err, busy);
    end
    @(negedge clk1);
    #1;
    checks++;
    if (err !== 1'b0 || busy !== 1'b0 || err_cnt - e0 != 1) begin
      failures++;
      $display("FAIL err_once: err=%b busy=%b pulses=%0d required 0 0 1", err, busy, err_cnt - e0);
    end
    d0 = done_cnt;
    r0 = rd_cnt;
    push_range(300, 2);
    do_start(300, 2);
    do_start(10, 5);
    collect(2, -1, 0, 40);
    wait_idle(10, d0, r0, 2);
    checks++;
    if (err_cnt - e0 != 1) begin
      failures++;
      $display("FAIL busy_start_err: pulses=%0d required 1", err_cnt - e0);
    end
  endtask

  task automatic test_reset_mid();
    int d0 = done_cnt;
    int r0;
    int cyc = 0;
    push_range(400, 3);
    do_start(400, 3);
    collect(1, -1, 0, 40);
    while (!bus.dump_valid && cyc < 10) begin
      @(negedge clk1);
      cyc++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.mem_rd_en, bus.mem_rd_addr, bus.dump_valid, bus.dump_addr, bus.dump_data,
         bus.dump_last, busy, done, err} !== '0 || cyc == 10) begin
      failures++;
      $display("FAIL mid_reset: valid=%b busy=%b addr=%0d required all 0 (wait %0d)",
               bus.dump_valid, busy, bus.dump_addr, cyc);
    end
    sb.delete();
    @(negedge clk1);
    rst_n = 1'b1;
    @(negedge clk1);
    #1;
    checks++;
    if (done_cnt != d0) begin
      failures++;
      $display("FAIL abort_done: pulses=%0d required 0", done_cnt - d0);
    end
    d0 = done_cnt;
    r0 = rd_cnt;
    push_range(0, 1);
    do_start(0, 1);
    collect(1, -1, 0, 40);
    wait_idle(10, d0, r0, 1);
  endtask

  initial begin
    bus.dump_ready = 1'b0;
    for (int i = 0; i < NWORDS; i++) mem[i] = $urandom;
    test_reset();
    test_program();
    test_wait_halt();
    test_backpressure();
    test_wrap_clip();
    test_err_busy();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
